instr_fetch_unit: RTL and testbench

// - Supplies 32-bit RV32I instructions to the CPU top's `instruction` input.
// - Replaces the fixed testbench stimulus with a PC-driven fetch from instruction memory.
// - Fetches over a req/ack memory handshake and presents each word to the decoder

---
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 tb/tb_instr_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC-driven fetch over a req/ack memory port, one-word
// buffer presented to the decoder over valid/ready, with branch redirect support.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instruction,
    input  logic        instr_ready,
    output logic [31:0] pc,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        misalign_err
);

    typedef enum logic [1:0] {StBoot, StReq, StHold, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] tgt_q, tgt_d;
    logic        misalign_q, misalign_d;
    logic [31:0] tgt_aligned;

    assign tgt_aligned = {branch_target[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        tgt_d      = tgt_q;
        misalign_d = branch_valid && (branch_target[1:0] != 2'b00);
        unique case (state_q)
            StBoot: begin
                state_d = StReq;
                if (branch_valid) pc_d = tgt_aligned;
            end
            StReq: begin
                if (branch_valid) begin
                    if (imem_ack) begin
                        pc_d = tgt_aligned;
                    end else begin
                        // Request already on the bus; wait for its ack before redirecting.
                        tgt_d   = tgt_aligned;
                        state_d = StDrop;
                    end
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = StHold;
                end
            end
            StHold: begin
                // A redirect wins over a simultaneous consume.
                if (branch_valid) begin
                    pc_d    = tgt_aligned;
                    instr_d = NOP_INSTR;
                    state_d = StReq;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    instr_d = NOP_INSTR;
                    state_d = StReq;
                end
            end
            StDrop: begin
                if (branch_valid) tgt_d = tgt_aligned;
                if (imem_ack) begin
                    pc_d    = branch_valid ? tgt_aligned : tgt_q;
                    state_d = StReq;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            tgt_q      <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            tgt_q      <= tgt_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req     = (state_q == StReq) || (state_q == StDrop);
    assign imem_addr    = pc_q;
    assign instr_valid  = (state_q == StHold);
    assign instruction  = (state_q == StHold) ? instr_q : NOP_INSTR;
    assign pc           = pc_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        instr_ready;
    logic [31:0] pc;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        misalign_err;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instruction  (instruction),
        .instr_ready  (instr_ready),
        .pc           (pc),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        instr_ready = 1'b0; branch_valid = 1'b0; branch_target = 32'h0;
        tick(); tick();
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %0h want 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0h want 0", instr_valid); end
        n_cmp++; if (instruction !== NOP) begin n_err++; $display("FAIL rst_instr got %h want %h", instruction, NOP); end
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h want 0", pc); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL rst_mis got %0h want 0", misalign_err); end
        imem_ack = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        tick(); // BOOT -> REQ
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL fetch_req got req=%0h addr=%h want 1/0", imem_req, imem_addr); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
                n_err++; $display("FAIL fetch_wait got req=%0h valid=%0h want 1/0", imem_req, instr_valid); end
        end
        imem_ack = 1'b1; imem_rdata = 32'h0091_1313;
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1 || instruction !== 32'h0091_1313) begin
            n_err++; $display("FAIL fetch_data got v=%0h i=%h want 1/00911313", instr_valid, instruction); end
        n_cmp++; if (imem_req !== 1'b0 || pc !== 32'h0) begin
            n_err++; $display("FAIL fetch_hold got req=%0h pc=%h want 0/0", imem_req, pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_cmp++; if (imem_addr !== 32'h4 || imem_req !== 1'b1 || instr_valid !== 1'b0 || instruction !== NOP) begin
            n_err++; $display("FAIL fetch_next got addr=%h req=%0h v=%0h i=%h want 4/1/0/nop",
                              imem_addr, imem_req, instr_valid, instruction); end
    endtask

    task automatic test_hold_stall();
        imem_ack = 1'b1; imem_rdata = 32'hAABB_CCDD;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (instr_valid !== 1'b1 || instruction !== 32'hAABB_CCDD || pc !== 32'h4 || imem_req !== 1'b0) begin
                n_err++; $display("FAIL stall cyc%0d got v=%0h i=%h pc=%h req=%0h want 1/aabbccdd/4/0",
                                  i, instr_valid, instruction, pc, imem_req); end
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL stall_next got %h want 8", imem_addr); end
    endtask

    task automatic test_branch_hold();
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (pc !== 32'h8 || instr_valid !== 1'b1) begin
            n_err++; $display("FAIL bh_pre got pc=%h v=%0h want 8/1", pc, instr_valid); end
        branch_valid = 1'b1; branch_target = 32'h40; instr_ready = 1'b1;
        tick();
        branch_valid = 1'b0; instr_ready = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || imem_addr !== 32'h40 || imem_req !== 1'b1 || misalign_err !== 1'b0) begin
            n_err++; $display("FAIL bh_redir got v=%0h addr=%h req=%0h mis=%0h want 0/40/1/0",
                              instr_valid, imem_addr, imem_req, misalign_err); end
    endtask

    task automatic test_branch_req();
        branch_valid = 1'b1; branch_target = 32'h60;
        tick();
        branch_target = 32'h80; // overwrite saved target while dropping
        tick();
        branch_valid = 1'b0;
        n_cmp++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin
            n_err++; $display("FAIL br_drop got addr=%h req=%0h want 40/1", imem_addr, imem_req); end
        tick();
        n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL br_drop2 got %h want 40", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (imem_addr !== 32'h80 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            n_err++; $display("FAIL br_redir got addr=%h v=%0h req=%0h want 80/0/1", imem_addr, instr_valid, imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (instruction !== 32'h1111_2222 || pc !== 32'h80) begin
            n_err++; $display("FAIL br_data got i=%h pc=%h want 11112222/80", instruction, pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_misalign();
        branch_valid = 1'b1; branch_target = 32'h0000_0106; imem_ack = 1'b1; imem_rdata = 32'hFFFF_0000;
        tick();
        branch_valid = 1'b0; imem_ack = 1'b0;
        n_cmp++; if (misalign_err !== 1'b1 || imem_addr !== 32'h104 || imem_req !== 1'b1) begin
            n_err++; $display("FAIL mis_pulse got mis=%0h addr=%h req=%0h want 1/104/1", misalign_err, imem_addr, imem_req); end
        tick();
        n_cmp++; if (misalign_err !== 1'b0 || imem_addr !== 32'h104) begin
            n_err++; $display("FAIL mis_clear got mis=%0h addr=%h want 0/104", misalign_err, imem_addr); end
    endtask

    task automatic test_wrap();
        branch_valid = 1'b1; branch_target = 32'hFFFF_FFFC; imem_ack = 1'b1;
        tick();
        branch_valid = 1'b0;
        imem_rdata = 32'h1357_9BDF;
        tick();
        imem_ack = 1'b0;
        n_cmp++; if (pc !== 32'hFFFF_FFFC || instruction !== 32'h1357_9BDF) begin
            n_err++; $display("FAIL wrap_hold got pc=%h i=%h want fffffffc/13579bdf", pc, instruction); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_cmp++; if (pc !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            n_err++; $display("FAIL wrap_pc got pc=%h addr=%h req=%0h want 0/0/1", pc, imem_addr, imem_req); end
    endtask

    task automatic test_reset_mid();
        branch_valid = 1'b1; branch_target = 32'h20; imem_ack = 1'b1;
        tick();
        branch_valid = 1'b0; imem_ack = 1'b0;
        n_cmp++; if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin
            n_err++; $display("FAIL rm_pre got addr=%h req=%0h want 20/1", imem_addr, imem_req); end
        #2 rst = 1'b1; imem_ack = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || pc !== 32'h0 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL rm_async got req=%0h pc=%h addr=%h want 0/0/0", imem_req, pc, imem_addr); end
        tick();
        rst = 1'b0;
        tick(); // BOOT with ack still high: ack ignored
        n_cmp++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL rm_boot got req=%0h v=%0h addr=%h want 1/0/0", imem_req, instr_valid, imem_addr); end
        imem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_hold_stall();
        test_branch_hold();
        test_branch_req();
        test_misalign();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
